// File: rtl/j_u2tx.sv
// rtl/j_u2tx.sv - UART2 transmitter: double-buffered serialiser timed by the 16x baud strobe
module j_u2tx #(
    parameter int DBITS = 8,
    parameter int OVS   = 16
) (
    input  logic             clk,
    input  logic             resetl,
    input  logic             bx16,
    input  logic [DBITS-1:0] din,
    input  logic             u2dataw,
    input  logic             pen,
    input  logic             podd,
    input  logic             txbrk,
    output logic             txd,
    output logic             txbe,
    output logic             tidle
);

    localparam int TW = $clog2(OVS);
    localparam int BW = $clog2(DBITS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]       r_state,  w_state;
    logic [TW-1:0]    r_tick,   w_tick;
    logic [BW-1:0]    r_bitcnt, w_bitcnt;
    logic [DBITS-1:0] r_hold,   w_hold;
    logic [DBITS-1:0] r_shift,  w_shift;
    logic             r_pen,    w_pen;
    logic             r_par,    w_par;
    logic             r_txbe,   w_txbe;
    logic             r_txd,    w_txd;
    logic             r_tidle;
    logic             w_run;
    logic             w_wrap;
    logic             w_load;

    always_comb begin
        w_state  = r_state;
        w_tick   = r_tick;
        w_bitcnt = r_bitcnt;
        w_hold   = r_hold;
        w_shift  = r_shift;
        w_pen    = r_pen;
        w_par    = r_par;
        w_txbe   = r_txbe;
        w_load   = 1'b0;
        w_run    = (r_state != S_IDLE) && bx16;
        w_wrap   = w_run && (r_tick == TW'(OVS - 1));

        if (w_run) begin
            w_tick = w_wrap ? '0 : r_tick + 1'b1;
        end

        case (r_state)
            S_IDLE: w_load = !r_txbe;
            S_START: begin
                if (w_wrap) begin
                    w_state  = S_DATA;
                    w_bitcnt = '0;
                end
            end
            S_DATA: begin
                if (w_wrap) begin
                    w_shift = r_shift >> 1;
                    if (r_bitcnt == BW'(DBITS - 1)) begin
                        w_state = r_pen ? S_PARITY : S_STOP;
                    end else begin
                        w_bitcnt = r_bitcnt + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (w_wrap) begin
                    w_state = S_STOP;
                end
            end
            S_STOP: begin
                if (w_wrap) begin
                    if (!r_txbe) begin
                        w_load = 1'b1;
                    end else begin
                        w_state = S_IDLE;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase

        // Transfer uses the old hold value; a write on the same edge refills hold behind it.
        if (w_load) begin
            w_state  = S_START;
            w_shift  = r_hold;
            w_pen    = pen;
            w_par    = podd ? ~^r_hold : ^r_hold;
            w_bitcnt = '0;
            w_tick   = '0;
            w_txbe   = 1'b1;
        end
        if (u2dataw) begin
            w_hold = din;
            w_txbe = 1'b0;
        end

        case (w_state)
            S_START:  w_txd = 1'b0;
            S_DATA:   w_txd = w_shift[0];
            S_PARITY: w_txd = w_par;
            default:  w_txd = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetl) begin
            r_state  <= S_IDLE;
            r_tick   <= '0;
            r_bitcnt <= '0;
            r_hold   <= '0;
            r_shift  <= '0;
            r_pen    <= 1'b0;
            r_par    <= 1'b0;
            r_txbe   <= 1'b1;
            r_txd    <= 1'b1;
            r_tidle  <= 1'b1;
        end else begin
            r_state  <= w_state;
            r_tick   <= w_tick;
            r_bitcnt <= w_bitcnt;
            r_hold   <= w_hold;
            r_shift  <= w_shift;
            r_pen    <= w_pen;
            r_par    <= w_par;
            r_txbe   <= w_txbe;
            r_txd    <= txbrk ? 1'b0 : w_txd;
            r_tidle  <= (w_state == S_IDLE) && w_txbe;
        end
    end

    assign txd   = r_txd;
    assign txbe  = r_txbe;
    assign tidle = r_tidle;

endmodule
